// File: rtl/l2_cache_pkg.sv
// Shared state encoding and default geometry for the L2 instruction cache.
package l2_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_FILL,
    RESPOND,
    FLUSH
  } state_e;

  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_NUM_SETS       = 64;
  localparam int DEF_NUM_WAYS       = 4;
  localparam int DEF_WORDS_PER_LINE = 4;

  localparam int OFFSET_BITS = $clog2(DEF_WORDS_PER_LINE);
  localparam int INDEX_BITS  = $clog2(DEF_NUM_SETS);
  localparam int TAG_BITS    = DEF_ADDR_WIDTH - INDEX_BITS - OFFSET_BITS - 2;
  localparam int AGE_BITS    = $clog2(DEF_NUM_WAYS);

  // Tag width for an arbitrary geometry; the two low byte-offset bits are never stored.
  function automatic int tag_bits(input int aw, input int sets, input int wpl);
    return aw - $clog2(sets) - $clog2(wpl) - 2;
  endfunction

endpackage

// File: rtl/l2_cache_lru.sv
// Per-set victim selection and LRU age update; purely combinational.
module l2_cache_lru #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0]            valid,
  input  logic [NUM_WAYS-1:0][WAY_W-1:0] age,
  input  logic [WAY_W-1:0]               hit_way,
  input  logic                           fill,
  output logic [WAY_W-1:0]               victim,
  output logic [NUM_WAYS-1:0][WAY_W-1:0] next_age
);

  logic             found;
  logic [WAY_W-1:0] upd_way;
  logic [WAY_W-1:0] old_age;

  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!valid[w] && !found) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age[w] == WAY_W'(NUM_WAYS-1)) victim = WAY_W'(w);
      end
    end
  end

  // Filling an invalid way ages every valid way, as if it had been the oldest.
  always_comb begin
    upd_way  = fill ? victim : hit_way;
    old_age  = valid[upd_way] ? age[upd_way] : WAY_W'(NUM_WAYS-1);
    next_age = age;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == upd_way)             next_age[w] = '0;
      else if (valid[w] && age[w] < old_age) next_age[w] = age[w] + 1'b1;
    end
  end

endmodule

// File: rtl/l2_assoc_instr_cache.sv
// Set-associative L2 I-cache: hit answers 1 cycle after accept, miss refills a full line from L3.
// One request per 2 cycles at best; req_ready is low outside IDLE, L3 request held until accepted.
module l2_assoc_instr_cache
  import l2_cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NUM_SETS       = DEF_NUM_SETS,
  parameter int NUM_WAYS       = DEF_NUM_WAYS,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic                  hit_o,
  output logic                  miss_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_rdata_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  flush_i
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int TAG_W = tag_bits(ADDR_WIDTH, NUM_SETS, WORDS_PER_LINE);

  state_e                         state_q, state_d;
  logic [ADDR_WIDTH-1:2]          addr_q;
  logic                           flush_pending;
  logic [IDX_W-1:0]               flush_set;
  logic [OFF_W-1:0]               beat_cnt;
  logic [DATA_WIDTH-1:0]          last_instr;
  logic [DATA_WIDTH-1:0]          rd_word;
  logic [DATA_WIDTH-1:0]          line_buf [WORDS_PER_LINE];

  logic [TAG_W-1:0]               tag_mem  [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0]          data_mem [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];
  logic [NUM_WAYS-1:0]            valid_q  [NUM_SETS];
  logic [NUM_WAYS-1:0][WAY_W-1:0] age_q    [NUM_SETS];

  logic [OFF_W-1:0]               off;
  logic [IDX_W-1:0]               set_idx;
  logic [TAG_W-1:0]               tag;
  logic                           is_hit, lru_upd, fill_en;
  logic [WAY_W-1:0]               hit_way, victim;
  logic [NUM_WAYS-1:0][WAY_W-1:0] next_age;
  logic                           unused_byte_bits;

  assign unused_byte_bits = ^addr_i[1:0];
  assign off        = addr_q[OFF_W+1:2];
  assign set_idx    = addr_q[IDX_W+OFF_W+1:OFF_W+2];
  assign tag        = addr_q[ADDR_WIDTH-1:IDX_W+OFF_W+2];
  assign mem_addr_o = {addr_q[ADDR_WIDTH-1:OFF_W+2], {(OFF_W+2){1'b0}}};
  assign instr_o    = instr_valid_o ? rd_word : last_instr;

  always_comb begin
    is_hit  = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[set_idx][w] && tag_mem[set_idx][w] == tag) begin
        is_hit  = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  l2_cache_lru #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_lru (
    .valid    (valid_q[set_idx]),
    .age      (age_q[set_idx]),
    .hit_way  (hit_way),
    .fill     (fill_en),
    .victim   (victim),
    .next_age (next_age)
  );

  always_comb begin
    state_d         = state_q;
    req_ready_o     = 1'b0;
    instr_valid_o   = 1'b0;
    hit_o           = 1'b0;
    miss_o          = 1'b0;
    mem_req_valid_o = 1'b0;
    lru_upd         = 1'b0;
    fill_en         = 1'b0;
    rd_word         = line_buf[off];
    case (state_q)
      IDLE: begin
        req_ready_o = !flush_i && !flush_pending;
        if (flush_i || flush_pending) state_d = FLUSH;
        else if (req_valid_i)         state_d = LOOKUP;
      end
      LOOKUP: begin
        if (is_hit) begin
          hit_o         = 1'b1;
          instr_valid_o = 1'b1;
          rd_word       = data_mem[set_idx][hit_way][off];
          lru_upd       = 1'b1;
          state_d       = IDLE;
        end else begin
          miss_o  = 1'b1;
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = MISS_FILL;
      end
      MISS_FILL: begin
        if (mem_rdata_valid_i && beat_cnt == OFF_W'(WORDS_PER_LINE-1)) begin
          fill_en = 1'b1;
          lru_upd = 1'b1;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        instr_valid_o = 1'b1;
        state_d       = flush_pending ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (flush_set == IDX_W'(NUM_SETS-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      flush_pending <= 1'b0;
      flush_set     <= '0;
      beat_cnt      <= '0;
      last_instr    <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        age_q[s]   <= '0;
      end
    end else begin
      state_q <= state_d;
      if (instr_valid_o) last_instr <= rd_word;
      if (state_q == IDLE && req_valid_i && req_ready_o) addr_q <= addr_i[ADDR_WIDTH-1:2];
      if (flush_i && state_q != IDLE && state_q != FLUSH) flush_pending <= 1'b1;
      if (state_q == MISS_REQ) beat_cnt <= '0;
      if (state_q == MISS_FILL && mem_rdata_valid_i) beat_cnt <= beat_cnt + 1'b1;
      if (lru_upd) age_q[set_idx] <= next_age;
      if (fill_en) valid_q[set_idx][victim] <= 1'b1;
      if (state_q == FLUSH) begin
        valid_q[flush_set] <= '0;
        age_q[flush_set]   <= '0;
        flush_set          <= flush_set + 1'b1;
        if (flush_set == IDX_W'(NUM_SETS-1)) flush_pending <= 1'b0;
      end
    end
  end

  // The last beat goes straight into the array; earlier beats come from the line buffer.
  always_ff @(posedge clk) begin
    if (state_q == MISS_FILL && mem_rdata_valid_i) line_buf[beat_cnt] <= mem_rdata_i;
    if (fill_en) begin
      tag_mem[set_idx][victim] <= tag;
      for (int i = 0; i < WORDS_PER_LINE-1; i++) data_mem[set_idx][victim][i] <= line_buf[i];
      data_mem[set_idx][victim][WORDS_PER_LINE-1] <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_l2_assoc_instr_cache.sv
// Bench for l2_assoc_instr_cache: vector table for hit/miss/LRU plus flush, backpressure and reset sequences.
module tb_l2_assoc_instr_cache;
  import l2_cache_pkg::*;

  logic        clk, rst_n;
  logic        req_valid_i, req_ready_o;
  logic [31:0] addr_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic        hit_o, miss_o;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_rdata_valid_i;
  logic [31:0] mem_rdata_i;
  logic        flush_i;

  int checks = 0;
  int failures = 0;

  int          rdy_delay = 0;
  int          beat_gap = 0;
  int          mem_req_cnt = 0;
  logic [31:0] last_mem_addr = '0;
  bit          model_busy = 0;

  typedef struct packed {
    logic        exp_hit;
    logic [31:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [31:0] addr;
    logic        exp_hit;
    int          exp_lat;
  } vec_t;
  vec_t tbl[16];

  l2_assoc_instr_cache dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .addr_i            (addr_i),
    .instr_valid_o     (instr_valid_o),
    .instr_o           (instr_o),
    .hit_o             (hit_o),
    .miss_o            (miss_o),
    .mem_req_valid_o   (mem_req_valid_o),
    .mem_req_ready_i   (mem_req_ready_i),
    .mem_addr_o        (mem_addr_o),
    .mem_rdata_valid_i (mem_rdata_valid_i),
    .mem_rdata_i       (mem_rdata_i),
    .flush_i           (flush_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a & 32'hFFFF_FFFC) ^ 32'hA5C3_0000;
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    logic [31:0] m;
    m = (32'd1 << (OFFSET_BITS + 2)) - 32'd1;
    return a & ~m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // L3 model: optional ready delay, optional idle gap before each beat.
  initial begin : l3_model
    logic [31:0] base;
    bit          stable;
    mem_req_ready_i   = 1'b0;
    mem_rdata_valid_i = 1'b0;
    mem_rdata_i       = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid_o && rst_n) begin
        model_busy = 1;
        base       = mem_addr_o;
        stable     = 1;
        for (int d = 0; d < rdy_delay; d++) begin
          @(negedge clk);
          if (!mem_req_valid_o || mem_addr_o !== base) stable = 0;
        end
        if (rdy_delay > 0) check("mem_req_held_stable", 32'(stable), 32'd1);
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        mem_req_cnt++;
        last_mem_addr = base;
        for (int i = 0; i < DEF_WORDS_PER_LINE; i++) begin
          repeat (beat_gap) begin
            mem_rdata_valid_i = 1'b0;
            mem_rdata_i       = 32'hDEAD_BEEF;
            @(negedge clk);
          end
          mem_rdata_valid_i = 1'b1;
          mem_rdata_i       = memword(base + 32'(4 * i));
          @(negedge clk);
        end
        mem_rdata_valid_i = 1'b0;
        mem_rdata_i       = 32'hDEAD_BEEF;
        model_busy        = 0;
      end
    end
  end

  // Issue one fetch; the expectation is queued at acceptance and checked when the response appears.
  task automatic fetch(input logic [31:0] a, input logic exp_hit, input int exp_lat);
    int  n, lat, cnt0;
    bit  got, saw_hit, saw_miss, rdy_seen;
    sb_t e;
    cnt0        = mem_req_cnt;
    req_valid_i = 1'b1;
    addr_i      = a;
    n = 0;
    while (!req_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    sb_q.push_back('{exp_hit: exp_hit, data: memword(a)});
    #1;
    req_valid_i = 1'b0;
    addr_i      = 32'hFFFF_FFFF;
    lat = 0; got = 0; saw_hit = 0; saw_miss = 0; rdy_seen = 0;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (hit_o)       saw_hit = 1;
      if (miss_o)      saw_miss = 1;
      if (req_ready_o) rdy_seen = 1;
      if (instr_valid_o && sb_q.size() > 0) begin
        got = 1;
        e   = sb_q.pop_front();
        check("instr_data", instr_o, e.data);
        check("hit_pulse", 32'(saw_hit), 32'(e.exp_hit));
        check("miss_pulse", 32'(saw_miss), 32'(!e.exp_hit));
      end
    end
    if (!got) begin
      check("response_timeout", 32'd0, 32'd1);
      return;
    end
    if (exp_lat > 0) check("latency", 32'(lat), 32'(exp_lat));
    check("ready_low_while_busy", 32'(rdy_seen), 32'd0);
    check("mem_req_count", 32'(mem_req_cnt - cnt0), exp_hit ? 32'd0 : 32'd1);
    if (!exp_hit) check("mem_addr", last_mem_addr, line_base(a));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  n;
    bit  flag;
    rst_n = 1'b0; req_valid_i = 1'b0; addr_i = '0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_instr_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_hit_miss", {30'd0, hit_o, miss_o}, 32'd0);
    check("rst_mem_req", 32'(mem_req_valid_o), 32'd0);

    // Cold miss/hit, then 6 lines into set 0 exercising LRU order.
    tbl[0]  = '{32'h0100, 1'b0, 7};
    tbl[1]  = '{32'h0108, 1'b1, 1};
    tbl[2]  = '{32'h0000, 1'b0, 7};
    tbl[3]  = '{32'h0404, 1'b0, 7};
    tbl[4]  = '{32'h0808, 1'b0, 7};
    tbl[5]  = '{32'h0C0C, 1'b0, 7};
    tbl[6]  = '{32'h1000, 1'b0, 7};
    tbl[7]  = '{32'h0400, 1'b1, 1};
    tbl[8]  = '{32'h1404, 1'b0, 7};
    tbl[9]  = '{32'h1008, 1'b1, 1};
    tbl[10] = '{32'h040C, 1'b1, 1};
    tbl[11] = '{32'h1400, 1'b1, 1};
    tbl[12] = '{32'h0C04, 1'b1, 1};
    tbl[13] = '{32'h0800, 1'b0, 7};
    tbl[14] = '{32'h0000, 1'b0, 7};
    tbl[15] = '{32'h0108, 1'b1, 1};
    for (int i = 0; i < 16; i++) begin
      fetch(tbl[i].addr, tbl[i].exp_hit, tbl[i].exp_lat);
      @(negedge clk);
      check("ready_after_response", 32'(req_ready_o), 32'd1);
    end

    // L3 backpressure and spaced beats.
    rdy_delay = 5; beat_gap = 2;
    fetch(32'h2A48, 1'b0, 0);
    rdy_delay = 0; beat_gap = 0;
    fetch(32'h2A48, 1'b1, 1);

    // Flush raised mid-refill: data still returned, then a full flush.
    beat_gap = 2;
    n = 0;
    fork
      fetch(32'h5554, 1'b0, 0);
      begin
        while (!mem_rdata_valid_i && n < 100) begin
          @(negedge clk);
          n++;
        end
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
      end
    join
    beat_gap = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready_o && n < 200);
    check("flush_after_refill_cycles", 32'(n), 32'(DEF_NUM_SETS + 1));
    fetch(32'h5554, 1'b0, 7);
    fetch(32'h0108, 1'b0, 7);

    // Simultaneous flush and request in IDLE.
    @(negedge clk);
    flush_i = 1'b1; req_valid_i = 1'b1; addr_i = 32'h5554;
    #1;
    check("flush_blocks_ready", 32'(req_ready_o), 32'd0);
    n = 0; flag = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) flush_i = 1'b0;
      if (hit_o || miss_o) flag = 1;
    end while (!req_ready_o && n < 200);
    check("flush_first_cycles", 32'(n), 32'(DEF_NUM_SETS + 1));
    check("no_lookup_during_flush", 32'(flag), 32'd0);
    fetch(32'h5554, 1'b0, 7);

    // Reset in the middle of a refill; remaining beats arrive as strays.
    @(negedge clk);
    beat_gap = 1;
    req_valid_i = 1'b1; addr_i = 32'h3330;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    n = 0;
    while (!mem_rdata_valid_i && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("beat_seen_before_reset", 32'(mem_rdata_valid_i), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_instr_valid", 32'(instr_valid_o), 32'd0);
    check("mid_rst_instr", instr_o, 32'd0);
    check("mid_rst_hit_miss", {30'd0, hit_o, miss_o}, 32'd0);
    check("mid_rst_mem_req", 32'(mem_req_valid_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0; flag = 0;
    while (model_busy && n < 100) begin
      @(negedge clk);
      n++;
      if (instr_valid_o || mem_req_valid_o) flag = 1;
    end
    check("stray_beats_done", 32'(model_busy), 32'd0);
    check("stray_beats_ignored", 32'(flag), 32'd0);
    check("ready_after_reset", 32'(req_ready_o), 32'd1);
    beat_gap = 0;
    fetch(32'h3330, 1'b0, 7);
    fetch(32'h3334, 1'b1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_assoc_instr_cache.md
# l2_assoc_instr_cache

Parametrised set-associative, multi-word-line L2 instruction cache. It sits between the L1 instruction cache and the L3/memory port. Beyond the single-word, always-refill L2 it adds:
- a valid/ready request handshake
- configurable line size with a multi-beat refill FSM
- true per-set LRU age tracking with invalid-way-first victim choice
- a sequenced full-cache flush
- an asynchronous active-low reset

## Interface
Parameters (name, default, meaning):
- ADDR_WIDTH, 32: byte-address width.
- DATA_WIDTH, 32: instruction/word width.
- NUM_SETS, 64: sets. Must be a power of two.
- NUM_WAYS, 4: ways per set. Must be a power of two, at least 2.
- WORDS_PER_LINE, 4: words per line. Must be a power of two, at least 2.

Ports (name, direction, width, meaning):
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- req_valid_i, in, 1: L1 fetch request valid.
- req_ready_o, out, 1: cache can accept a request.
- addr_i, in, ADDR_WIDTH: fetch byte address. Bits [1:0] are ignored.
- instr_valid_o, out, 1: one-cycle response strobe.
- instr_o, out, DATA_WIDTH: response word. Holds its last value when instr_valid_o is low.
- hit_o, out, 1: one-cycle pulse on a lookup hit.
- miss_o, out, 1: one-cycle pulse on a lookup miss.
- mem_req_valid_o, out, 1: line refill request to L3.
- mem_req_ready_i, in, 1: L3 accepts the request.
- mem_addr_o, out, ADDR_WIDTH: line-aligned byte address; offset bits are zero.
- mem_rdata_valid_i, in, 1: refill beat valid.
- mem_rdata_i, in, DATA_WIDTH: refill beat, returned in ascending word order.
- flush_i, in, 1: invalidate the whole cache.

## Operation
Address split and storage:
- Address fields: word offset = log2(WORDS_PER_LINE) bits above bits [1:0]; set index = log2(NUM_SETS) bits above that; tag = the remaining upper bits.
- Storage per set and way: tag, data line, valid bit, and an age of log2(NUM_WAYS) bits.
- Valid and age are flops. Tag and data arrays are not reset.

FSM states: IDLE, LOOKUP, MISS_REQ, MISS_FILL, RESPOND, FLUSH.
- IDLE: req_ready_o = !flush_i && !flush_pending. On req_valid_i && req_ready_o, register addr_i and go to LOOKUP.
- LOOKUP, hit: compare the registered tag against all valid ways. On a hit assert hit_o, drive instr_valid_o with the addressed word, apply the LRU update, go to IDLE.
- LOOKUP, miss: assert miss_o and go to MISS_REQ.
- MISS_REQ: mem_req_valid_o = 1, with mem_addr_o set to the line base. Hold both until mem_req_ready_i, then go to MISS_FILL and clear the beat counter.
- MISS_FILL: each mem_rdata_valid_i writes beat[count] into the line buffer and increments count.
  - On the beat where count = WORDS_PER_LINE-1, write tag, line and valid into the victim way, apply the LRU update, go to RESPOND.
  - mem_rdata_valid_i is ignored in every other state.
- RESPOND: instr_valid_o = 1, with instr_o taken from the filled line at the requested offset. Go to FLUSH if flush_pending, else IDLE.
- FLUSH: clear valid and age for one set per cycle, in ascending set order. After set NUM_SETS-1, clear flush_pending and go to IDLE.

Flush rules:
- flush_i in IDLE goes straight to FLUSH and wins over a simultaneous request, which is not accepted.
- flush_i in any other state sets flush_pending. The in-flight fetch completes and returns the refilled data, then the flush runs.
- flush_i during FLUSH has no extra effect.

Victim choice and LRU:
- Victim = the lowest-index invalid way; otherwise the way with age = NUM_WAYS-1.
- Update on a hit or fill of way w, with old age a: age[w] = 0, and every other valid way with age < a increments. For a fill into an invalid way, a = NUM_WAYS-1.
- Ages within a set therefore stay a permutation of the valid ways.

Reset:
- rst_n low forces: IDLE, all valid = 0, all ages = 0, flush_pending = 0, beat counter = 0, instr_o = 0.
- All strobes are 0 and mem_req_valid_o = 0.
- req_ready_o is 1 after release, provided flush_i is low.
- Reset mid-refill abandons the refill. Late L3 beats are ignored because the cache is back in IDLE.

## Timing
- Request accepted at edge k:
  - hit: hit_o and instr_valid_o high in cycle k+1, req_ready_o high again in cycle k+2.
  - miss, zero-wait L3: miss_o in cycle k+1, MISS_REQ in k+2, beats in k+3..k+2+WORDS_PER_LINE, RESPOND in k+3+WORDS_PER_LINE.
- Throughput is at most one request per 2 cycles, because req_ready_o is high only in IDLE.
- Flush takes NUM_SETS cycles in FLUSH.
- mem_req_valid_o, once raised, stays high with a stable address until accepted.

## Structure
- Package l2_cache_pkg holds:
  - the state enum type
  - localparam helpers: OFFSET_BITS, INDEX_BITS, TAG_BITS, AGE_BITS, derived from the parameters
- Sub-module l2_cache_lru: combinational. It takes one set's valid and age vectors plus hit_way/fill flags, and returns the victim way and the next ages.
- The top level holds the FSM, arrays, line buffer and beat counter.

## Test plan
Defaults (4 ways, 4 words per line) unless stated.
1. Cold miss then hit: fetch 0x100 with L3 beats A0..A3 -> miss_o, single mem_addr_o=0x100, instr_o=A0 at k+7. Refetch 0x108 -> hit_o and instr_o=A2 at k+1.
2. LRU eviction: fill 5 lines mapping to set 0 in order L0..L4 -> L4 replaces L0. Touch L1 before fetching L5 -> L5 replaces L2.
3. L3 backpressure: hold mem_req_ready_i low 5 cycles, space beats 2 cycles apart -> request held stable, correct word returned, req_ready_o low throughout.
4. Flush mid-refill: assert flush_i in MISS_FILL -> refill data returned, then 64 FLUSH cycles, then a refetch of the same address misses.
5. Simultaneous flush_i and req_valid_i in IDLE -> request not accepted, flush runs first.
6. Reset during MISS_FILL, then stray beats -> all outputs 0, beats ignored, next fetch misses.
